pokey_chan_pair: RTL and testbench
==================================

// Module: pokey_chan_pair
// PURPOSE
//   Audio channel-pair divider stage. Two 8-bit down-counters (A = low channel, B = high channel)
//   take the base-clock ticks from the prescaler and emit borrow pulses and square-wave tones.
//   These outputs feed the distortion/poly gating and the IRQ timers. Join mode chains A:B into
//   one 16-bit divider. Each channel can run at the full 1.79 MHz rate with POKEY-accurate
//   period offsets.
// PARAMETERS
//   CNT_W      8   width of one channel divider / AUDF register
//   FAST_OFS8  3   extra reload count, 8-bit channel at 1.79 MHz (period = AUDF+4)
//   FAST_OFS16 6   extra reload count, joined pair at 1.79 MHz (period = AUDF16+7)
// PORTS
//   clk        in   1      system clock (1.79 MHz domain); all state updates on posedge
//   rst_n      in   1      synchronous reset, active low
//   tick_base  in   1      base-clock enable pulse (64 kHz or 15 kHz, selected upstream), 1 clk wide
//   fast_a     in   1      1 = channel A counts every clk instead of tick_base
//   fast_b     in   1      1 = channel B (join: the pair) counts every clk
//   join       in   1      1 = A:B form one 16-bit counter, A = low byte
//   audf_a     in   CNT_W  reload value, channel A
//   audf_b     in   CNT_W  reload value, channel B
//   stimer     in   1      1-clk strobe: force reload of both counters
//   hp_tick    in   1      high-pass clock (borrow of the partner pair); used only with HIPASS_EN
//   borrow_a   out  1      1-clk pulse on channel A underflow (held 0 in join mode)
//   borrow_b   out  1      1-clk pulse on channel B / joined-pair underflow
//   tone_a     out  1      toggles on each borrow_a
//   tone_b     out  1      toggles on each borrow_b
//   tone_a_hp  out  1      channel A tone after optional high-pass stage
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): counters=0, borrow_a/b=0, tone_a/b=0, hp flop=0. Reset wins
//     over every other input.
//   - Count enable: en_a = fast_a ? 1 : tick_base. en_b = fast_b ? 1 : tick_base.
//   - 8-bit mode, per channel: on enable, cnt==0 -> reload and assert borrow next cycle;
//     otherwise cnt-1. Reload value = audf + (fast ? FAST_OFS8 : 0).
//   - Counters are CNT_W+1 bits wide (AUDF=FF fast loads 0x102). No wrap.
//   - Period in enables = reload+1. Example: fast, AUDF=0 -> borrow every 4 clk.
//   - Join mode: a single CNT_W*2+1 counter is clocked by en_b. Reload = {audf_b,audf_a} +
//     (fast_b ? FAST_OFS16 : 0). Underflow drives borrow_b/tone_b only.
//     borrow_a=0 and tone_a holds in join mode.
//   - Registered outputs: borrow is registered and is high exactly 1 clk, in the cycle after the
//     enable that saw cnt==0. The tone toggle is in the same cycle as its borrow.
//   - AUDF, fast and join changes are not applied mid-count. They take effect at the next reload.
//     Exception: a join change also forces an immediate reload of both counters, with no borrow.
//   - stimer: both counters reload from the current audf/fast/join, tone_a/b cleared, no borrow
//     issued.
//   - stimer coincident with an enable at cnt==0: stimer wins, no borrow.
//   - Back-to-back enables (fast mode) at cnt==0: the reload happens in the same clk as
//     detection, so no enable is lost.
// CONFIGURATION
//   HIPASS_EN defined: flop hp <= tone_a on each hp_tick (reset 0); tone_a_hp = tone_a ^ hp.
//     tone_a_hp is combinational from the registers.
//   HIPASS_EN undefined: tone_a_hp = tone_a; hp_tick ignored; no hp flop synthesised.
// TESTING
//   1. fast_a=1, audf_a=0, join=0 -> borrow_a every 4 clk; tone_a period 8 clk.
//   2. fast_a=0, audf_a=2, tick_base every 28 clk -> borrow_a once per 3 ticks, 1 clk after
//      the tick.
//   3. join=1, fast_b=1, audf_b=0x01, audf_a=0x00 -> borrow_b every 0x100+7=263 clk;
//      borrow_a stays 0.
//   4. stimer mid-count (cnt=5), then coincident with a cnt==0 tick -> counters reload, tone_a/b
//      go 0, no borrow in either case.
//   5. rst_n=0 mid-count for 1 clk -> all outputs 0 next cycle; first enable after reset gives a
//      borrow 1 clk later.
//   6. HIPASS_EN: tone_a high, pulse hp_tick -> tone_a_hp=0. Toggle tone_a -> tone_a_hp=1.
//      Without the macro, tone_a_hp tracks tone_a exactly.

Source files
------------

// File: rtl/pokey_chan_pair.sv
// pokey_chan_pair: POKEY audio channel-pair divider, two 8-bit or one joined 16-bit down-counter.
// Define HIPASS_EN to add the channel-A high-pass flop clocked by i_hp_tick.
module pokey_chan_pair #(
  parameter int CNT_W      = 8,
  parameter int FAST_OFS8  = 3,
  parameter int FAST_OFS16 = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick_base,
  input  logic             i_fast_a,
  input  logic             i_fast_b,
  input  logic             i_join,
  input  logic [CNT_W-1:0] i_audf_a,
  input  logic [CNT_W-1:0] i_audf_b,
  input  logic             i_stimer,
  input  logic             i_hp_tick,
  output logic             o_borrow_a,
  output logic             o_borrow_b,
  output logic             o_tone_a,
  output logic             o_tone_b,
  output logic             o_tone_a_hp
);
  localparam int JW = 2*CNT_W + 1;
  localparam logic [CNT_W:0]  L_OFS8  = (CNT_W+1)'(FAST_OFS8);
  localparam logic [CNT_W:0]  L_ONE8  = (CNT_W+1)'(1);
  localparam logic [JW-1:0]   L_OFS16 = JW'(FAST_OFS16);
  localparam logic [JW-1:0]   L_ONE16 = JW'(1);
  logic [CNT_W:0] r_cnt_a, r_cnt_b, w_rel_a, w_rel_b;
  logic [JW-1:0]  r_cnt_j, w_rel_j;
  logic r_join, r_bor_a, r_bor_b, r_tone_a, r_tone_b;
  logic w_en_a, w_en_b, w_force, w_uf_a, w_uf_b;
  always_comb begin
    w_en_a  = i_fast_a | i_tick_base;
    w_en_b  = i_fast_b | i_tick_base;
    w_rel_a = {1'b0, i_audf_a} + (i_fast_a ? L_OFS8 : '0);
    w_rel_b = {1'b0, i_audf_b} + (i_fast_b ? L_OFS8 : '0);
    w_rel_j = {1'b0, i_audf_b, i_audf_a} + (i_fast_b ? L_OFS16 : '0);
    w_force = i_stimer | (i_join ^ r_join);
    w_uf_a  = !r_join && w_en_a && r_cnt_a == '0;
    w_uf_b  = w_en_b && (r_join ? r_cnt_j == '0 : r_cnt_b == '0);
  end
  // A join change reloads everything at once, so the new mode never starts from a stale count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt_a  <= '0;
      r_cnt_b  <= '0;
      r_cnt_j  <= '0;
      r_bor_a  <= 1'b0;
      r_bor_b  <= 1'b0;
      r_tone_a <= 1'b0;
      r_tone_b <= 1'b0;
      r_join   <= i_join;
    end else begin
      r_join   <= i_join;
      r_bor_a  <= w_uf_a & ~w_force;
      r_bor_b  <= w_uf_b & ~w_force;
      r_tone_a <= i_stimer ? 1'b0 : r_tone_a ^ (w_uf_a & ~w_force);
      r_tone_b <= i_stimer ? 1'b0 : r_tone_b ^ (w_uf_b & ~w_force);
      r_cnt_a  <= (w_force || w_uf_a) ? w_rel_a
                : (!r_join && w_en_a) ? r_cnt_a - L_ONE8 : r_cnt_a;
      r_cnt_b  <= (w_force || (!r_join && w_uf_b)) ? w_rel_b
                : (!r_join && w_en_b) ? r_cnt_b - L_ONE8 : r_cnt_b;
      r_cnt_j  <= (w_force || (r_join && w_uf_b)) ? w_rel_j
                : (r_join && w_en_b) ? r_cnt_j - L_ONE16 : r_cnt_j;
    end
  end
  assign o_borrow_a = r_bor_a;
  assign o_borrow_b = r_bor_b;
  assign o_tone_a   = r_tone_a;
  assign o_tone_b   = r_tone_b;
`ifdef HIPASS_EN
  logic r_hp;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_hp <= 1'b0;
    else if (i_hp_tick) r_hp <= r_tone_a;
  end
  assign o_tone_a_hp = r_tone_a ^ r_hp;
`else
  logic w_unused;
  assign w_unused    = i_hp_tick;
  assign o_tone_a_hp = r_tone_a;
`endif
endmodule

// File: tb/tb_pokey_chan_pair.sv
// tb_pokey_chan_pair: directed bench with a borrow/tone scoreboard for pokey_chan_pair.
module tb_pokey_chan_pair;
  logic clk = 0, rst_n = 0, tick = 0, fast_a = 0, fast_b = 0, jn = 0, stimer = 0, hp_tick = 0;
  logic [7:0] audf_a = 0, audf_b = 0;
  logic borrow_a, borrow_b, tone_a, tone_b, tone_a_hp;
  int cyc = 0, checks = 0, failures = 0;
  bit mon_en = 0, ta = 0, tb = 0;
  typedef struct {int c; logic t;} ev_t;
  ev_t qa[$], qb[$];
`ifdef HIPASS_EN
  localparam bit HP = 1;
`else
  localparam bit HP = 0;
`endif
  pokey_chan_pair dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick_base(tick), .i_fast_a(fast_a), .i_fast_b(fast_b),
    .i_join(jn), .i_audf_a(audf_a), .i_audf_b(audf_b), .i_stimer(stimer), .i_hp_tick(hp_tick),
    .o_borrow_a(borrow_a), .o_borrow_b(borrow_b), .o_tone_a(tone_a), .o_tone_b(tone_b),
    .o_tone_a_hp(tone_a_hp)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask
  task automatic check_n(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask
  task automatic push_a(input int c);
    ta = ~ta;
    qa.push_back('{c, ta});
  endtask
  task automatic push_b(input int c);
    tb = ~tb;
    qb.push_back('{c, tb});
  endtask
  task automatic pulse(input bit pa, input bit pb, input int gap);
    tick = 1;
    if (pa) push_a(cyc + 1);
    if (pb) push_b(cyc + 1);
    step(1);
    tick = 0;
    step(gap - 1);
  endtask
  task automatic do_reset();
    check_n("pending_a", qa.size(), 0);
    check_n("pending_b", qb.size(), 0);
    rst_n = 0;
    step(1);
    rst_n = 1;
    ta = 0;
    tb = 0;
  endtask
  always @(negedge clk) begin
    bit ea, eb;
    if (mon_en) begin
      ea = qa.size() > 0 && qa[0].c == cyc;
      eb = qb.size() > 0 && qb[0].c == cyc;
      check("borrow_a", borrow_a, ea);
      check("borrow_b", borrow_b, eb);
      if (ea) begin
        check("tone_a", tone_a, qa[0].t);
        void'(qa.pop_front());
      end
      if (eb) begin
        check("tone_b", tone_b, qb[0].t);
        void'(qb.pop_front());
      end
    end
  end
  initial begin
    step(2);
    mon_en = 1;
    check("rst_tone_a", tone_a, 0);
    check("rst_tone_b", tone_b, 0);
    check("rst_tone_a_hp", tone_a_hp, 0);
    // fast A, AUDF=0: borrow every 4 clk
    fast_a = 1;
    rst_n = 1;
    for (int k = 0; k < 6; k++) push_a(cyc + 1 + 4*k);
    step(22);
    fast_a = 0;
    step(2);
    // slow A, AUDF=2: borrow once per 3 ticks; B with AUDF=0 borrows on every tick
    audf_a = 2;
    do_reset();
    for (int i = 0; i < 7; i++) pulse(i % 3 == 0, 1, 28);
    // joined fast pair {01,00}: period 263, A stays silent despite fast_a
    jn = 1; fast_a = 1; audf_a = 0; audf_b = 8'h01;
    do_reset();
    fast_b = 1;
    push_b(cyc + 1); push_b(cyc + 264); push_b(cyc + 527);
    step(530);
    fast_b = 0; fast_a = 0;
    step(2);
    // fast 8-bit B at AUDF=FF: reload 0x102, period 259
    jn = 0; audf_b = 8'hFF;
    do_reset();
    fast_b = 1;
    push_b(cyc + 1); push_b(cyc + 260);
    step(262);
    fast_b = 0;
    step(2);
    // stimer mid-count, then coincident with an underflowing tick
    audf_a = 7; audf_b = 7;
    do_reset();
    pulse(1, 1, 4); pulse(0, 0, 4); pulse(0, 0, 4);
    check("pre_stimer_tone_a", tone_a, 1);
    stimer = 1;
    step(1);
    stimer = 0; ta = 0; tb = 0;
    check("stimer_tone_a", tone_a, 0);
    check("stimer_tone_b", tone_b, 0);
    repeat (7) pulse(0, 0, 4);
    pulse(1, 1, 4);
    repeat (7) pulse(0, 0, 4);
    stimer = 1; tick = 1;
    step(1);
    stimer = 0; tick = 0; ta = 0; tb = 0;
    check("coinc_tone_a", tone_a, 0);
    check("coinc_tone_b", tone_b, 0);
    step(3);
    repeat (7) pulse(0, 0, 4);
    pulse(1, 1, 4);
    // reset mid-count
    audf_a = 5;
    do_reset();
    fast_a = 1;
    push_a(cyc + 1);
    step(5);
    rst_n = 0;
    step(1);
    check("mid_rst_borrow_a", borrow_a, 0);
    check("mid_rst_borrow_b", borrow_b, 0);
    check("mid_rst_tone_a", tone_a, 0);
    check("mid_rst_tone_b", tone_b, 0);
    check("mid_rst_tone_a_hp", tone_a_hp, 0);
    rst_n = 1; ta = 0; tb = 0;
    push_a(cyc + 1);
    step(1);
    fast_a = 0;
    step(2);
    // high-pass stage
    audf_a = 0; audf_b = 0;
    do_reset();
    check("hp_after_rst", tone_a_hp, 0);
    pulse(1, 1, 4);
    hp_tick = 1;
    step(1);
    hp_tick = 0;
    check("hp_tone_high", tone_a_hp, HP ? 1'b0 : 1'b1);
    pulse(1, 1, 4);
    check("hp_tone_toggled", tone_a_hp, HP ? 1'b1 : 1'b0);
    step(2);
    check_n("final_pending_a", qa.size(), 0);
    check_n("final_pending_b", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
